// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes big-endian
// 32-bit words into instruction memory. It holds the MIPS core in reset until the image verifies.
module imem_boot_loader #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      ADDR_WIDTH = 10,
  parameter logic [WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BL_Start,
  input  logic [7:0]       BL_RxData,
  input  logic             BL_RxValid,
  output logic             BL_RxReady,
  output logic             BL_ImemWrEn,
  output logic [WIDTH-1:0] BL_ImemAddr,
  output logic [WIDTH-1:0] BL_ImemWrData,
  output logic             BL_CoreRstN,
  output logic             BL_Busy,
  output logic             BL_Done,
  output logic             BL_Error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  // One extra bit so a full-depth image (2**ADDR_WIDTH words) is representable.
  localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_WIDTH);

  logic [2:0]          state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_WIDTH:0] idx_q, idx_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [7:0]          csum_q, csum_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic [WIDTH-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0]    data_q, data_d;

  logic                rxReady;
  logic                xfer;
  logic [15:0]         lenNew;
  logic [ADDR_WIDTH:0] idxInc;
  logic [WIDTH-1:0]    wordNew;

  assign rxReady = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer    = BL_RxValid & rxReady;
  assign lenNew  = {len_q[15:8], BL_RxData};
  assign idxInc  = idx_q + (ADDR_WIDTH + 1)'(1);
  assign wordNew = {word_q[WIDTH-9:0], BL_RxData};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (BL_Start) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {BL_RxData, 8'h00};
          csum_d  = csum_q ^ BL_RxData;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d  = lenNew;
          csum_d = csum_q ^ BL_RxData;
          if ({1'b0, lenNew} > MAX_WORDS) state_d = S_ERROR;
          else if (lenNew == 16'd0)      state_d = S_CHECK;
          else                           state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ BL_RxData;
          word_d = wordNew;
          cnt_d  = cnt_q + 2'd1;
          // Address and data are latched here so they are valid throughout WRITE and hold after.
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
            data_d  = wordNew;
            addr_d  = BASE_ADDR + (WIDTH'(idx_q) << 2);
          end
        end
      end
      S_WRITE: begin
        idx_d   = idxInc;
        state_d = (32'(idxInc) == 32'(len_q)) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (xfer) state_d = (BL_RxData == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign BL_RxReady    = rxReady;
  assign BL_ImemWrEn   = (state_q == S_WRITE);
  assign BL_ImemAddr   = addr_q;
  assign BL_ImemWrData = data_q;
  assign BL_CoreRstN   = (state_q == S_DONE);
  assign BL_Busy       = rxReady || (state_q == S_WRITE);
  assign BL_Done       = (state_q == S_DONE);
  assign BL_Error      = (state_q == S_ERROR);

endmodule
